fmul_sched: RTL and testbench

FMUL_SCHED -- requirements
Module: fmul_sched

---
 rtl/fmul_sched.sv | 141 ++++++++++++++
 tb/tb_fmul_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_sched.sv
// Round-robin scheduler that shares one combinational FP multiplier among NREQ requesters.
// Each requester owns a one-entry result slot; error and overflow results are counted.
module fmul_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic                 mul_sign,
  input  logic [7:0]           mul_exp,
  input  logic [23:0]          mul_frac,
  input  logic                 mul_error,
  input  logic                 mul_overflow,
  output logic                 mul_active,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*35-1:0]   rsp_data,
  input  logic                 cnt_clr,
  output logic [CNTW-1:0]      err_count,
  output logic [CNTW-1:0]      ovf_count
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic            op_valid_q;
  logic [IW-1:0]   op_id_q;
  logic [31:0]     op_a_q, op_b_q;
  logic [NREQ-1:0] slot_full_q;
  logic [34:0]     slot_q [NREQ];
  logic [CNTW-1:0] err_q, err_d, ovf_q, ovf_d;

  logic [NREQ-1:0] eligible;
  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic [31:0]     sel_a, sel_b;
  logic [34:0]     result;

  assign result = {mul_error, mul_overflow, mul_sign, mul_exp, mul_frac};

  // A requester with an op already in flight or an unread result may not issue again.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] & ~slot_full_q[i] & ~(op_valid_q && (op_id_q == IW'(i)));
    end
  end

  always_comb begin
    int unsigned  idx;
    logic [IW-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx  = (32'(ptr_q) + k) % NREQ;
      cand = IW'(idx);
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!rst_n) gnt_any = 1'b0;
    req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    ptr_d     = gnt_any ? IW'((32'(gnt_idx) + 1) % NREQ) : ptr_q;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    err_d = err_q;
    ovf_d = ovf_q;
    if (cnt_clr) begin
      err_d = '0;
      ovf_d = '0;
    end else if (op_valid_q) begin
      if (mul_error && !(&err_q))    err_d = err_q + CNTW'(1);
      if (mul_overflow && !(&ovf_q)) ovf_d = ovf_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      op_valid_q  <= 1'b0;
      op_id_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      slot_full_q <= '0;
      err_q       <= '0;
      ovf_q       <= '0;
      for (int unsigned i = 0; i < NREQ; i++) slot_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      op_valid_q <= gnt_any;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      if (gnt_any) begin
        op_id_q <= gnt_idx;
        op_a_q  <= sel_a;
        op_b_q  <= sel_b;
      end
      // Write and pop of one slot never coincide: a full slot is never eligible to issue.
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (op_valid_q && (op_id_q == IW'(i))) begin
          slot_q[i]      <= result;
          slot_full_q[i] <= 1'b1;
        end else if (slot_full_q[i] && rsp_ready[i]) begin
          slot_full_q[i] <= 1'b0;
        end
      end
    end
  end

  assign mul_a      = op_valid_q ? op_a_q : '0;
  assign mul_b      = op_valid_q ? op_b_q : '0;
  assign mul_active = op_valid_q;
  assign rsp_valid  = slot_full_q;
  assign err_count  = err_q;
  assign ovf_count  = ovf_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_rsp
    assign rsp_data[35*g +: 35] = slot_q[g];
  end

endmodule

// File: tb/tb_fmul_sched.sv
// Directed bench for fmul_sched with a behavioural FP multiplier model.
// A second instance with 2-bit counters exercises counter saturation.
module tb_fmul_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready, req_ready2;
  logic [127:0] req_a, req_b;
  logic [31:0]  mul_a, mul_b, mul_a2, mul_b2;
  logic         mul_sign, mul_error, mul_overflow, mul_active, mul_active2;
  logic [7:0]   mul_exp;
  logic [23:0]  mul_frac;
  logic [3:0]   rsp_valid, rsp_valid2, rsp_ready;
  logic [139:0] rsp_data, rsp_data2;
  logic         cnt_clr;
  logic [15:0]  err_count, ovf_count;
  logic [1:0]   err_count2, ovf_count2;

  int total = 0;
  int bad = 0;
  int inv_bad = 0;

  always #5 clk = ~clk;

  fmul_sched #(.NREQ(4), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign(mul_sign), .mul_exp(mul_exp), .mul_frac(mul_frac),
    .mul_error(mul_error), .mul_overflow(mul_overflow), .mul_active(mul_active),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cnt_clr(cnt_clr), .err_count(err_count), .ovf_count(ovf_count)
  );

  fmul_sched #(.NREQ(4), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a2), .mul_b(mul_b2),
    .mul_sign(mul_sign), .mul_exp(mul_exp), .mul_frac(mul_frac),
    .mul_error(mul_error), .mul_overflow(mul_overflow), .mul_active(mul_active2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
    .cnt_clr(cnt_clr), .err_count(err_count2), .ovf_count(ovf_count2)
  );

  // Simplified FP multiply: truncating, no denormals.
  int          ea, eb, es;
  logic [47:0] prod;
  always_comb begin
    ea   = int'(mul_a[30:23]);
    eb   = int'(mul_b[30:23]);
    es   = ea + eb - 127;
    prod = 48'({1'b1, mul_a[22:0]}) * 48'({1'b1, mul_b[22:0]});
    if (prod[47]) begin
      mul_frac = prod[47:24];
      es       = es + 1;
    end else begin
      mul_frac = prod[46:23];
    end
    mul_sign     = mul_a[31] ^ mul_b[31];
    mul_exp      = es[7:0];
    mul_overflow = (es > 254);
    mul_error    = ((ea == 255) && (mul_a[22:0] == 0) && (eb == 0)) ||
                   ((eb == 255) && (mul_b[22:0] == 0) && (ea == 0));
  end

  // Invariant monitor: the slot being written must never be popped in the same cycle.
  logic       iss_v = 1'b0;
  logic [1:0] iss_id = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      iss_v <= 1'b0;
    end else begin
      if (iss_v && rsp_valid[iss_id] && rsp_ready[iss_id]) begin
        inv_bad <= inv_bad + 1;
        $display("FAIL slot_write_pop id=%0d", iss_id);
      end
      iss_v <= |(req_valid & req_ready);
      for (int i = 0; i < 4; i++) if (req_ready[i] && req_valid[i]) iss_id <= 2'(i);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_ops(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 4'h0; cnt_clr = 1'b0;
    set_all_ops(32'h3F800000, 32'h3F800000);
    tick; tick;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL rst_req_ready got=%h exp=0", req_ready); end
    total++; if (mul_a !== 32'h0) begin bad++; $display("FAIL rst_mul_a got=%h exp=0", mul_a); end
    total++; if (mul_b !== 32'h0) begin bad++; $display("FAIL rst_mul_b got=%h exp=0", mul_b); end
    total++; if (mul_active !== 1'b0) begin bad++; $display("FAIL rst_mul_active got=%b exp=0", mul_active); end
    total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL rst_rsp_valid got=%h exp=0", rsp_valid); end
    total++; if (rsp_data !== 140'h0) begin bad++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL rst_err_count got=%h exp=0", err_count); end
    total++; if (ovf_count !== 16'h0) begin bad++; $display("FAIL rst_ovf_count got=%h exp=0", ovf_count); end
    req_valid = 4'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40400000;
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    tick;
    req_valid = 4'h0;
    #1;
    total++; if (mul_active !== 1'b1) begin bad++; $display("FAIL single_active got=%b exp=1", mul_active); end
    total++; if (mul_a !== 32'h40000000) begin bad++; $display("FAIL single_mul_a got=%h exp=40000000", mul_a); end
    total++; if (mul_b !== 32'h40400000) begin bad++; $display("FAIL single_mul_b got=%h exp=40400000", mul_b); end
    total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL single_early_rsp got=%b exp=0000", rsp_valid); end
    tick;
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    total++; if (rsp_data[34:0] !== 35'h081C00000) begin bad++; $display("FAIL single_data got=%h exp=081c00000", rsp_data[34:0]); end
    total++; if (mul_a !== 32'h0) begin bad++; $display("FAIL single_idle_mul_a got=%h exp=0", mul_a); end
    tick;
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_hold got=%b exp=0001", rsp_valid); end
    rsp_ready = 4'hF;
    tick;
    total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL single_pop got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_contention;
    logic [3:0] exp_gnt [8];
    exp_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    set_all_ops(32'h3F800000, 32'h3F800000);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++;
      if (req_ready !== exp_gnt[k]) begin
        bad++; $display("FAIL contention_grant[%0d] got=%b exp=%b", k, req_ready, exp_gnt[k]);
      end
      tick;
    end
    req_valid = 4'h0;
    tick; tick; tick;
  endtask

  task automatic test_backpressure;
    req_a[95:64] = 32'h3F800000;
    req_b[95:64] = 32'h40000000;
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
    tick;
    req_b[95:64] = 32'h12345678;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL bp_inflight_ready got=%b exp=0000", req_ready); end
    total++; if (mul_b !== 32'h40000000) begin bad++; $display("FAIL bp_mul_b got=%h exp=40000000", mul_b); end
    tick;
    total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL bp_rsp_valid got=%b exp=0100", rsp_valid); end
    total++; if (rsp_data[104:70] !== 35'h080800000) begin bad++; $display("FAIL bp_data got=%h exp=080800000", rsp_data[104:70]); end
    for (int k = 0; k < 3; k++) begin
      tick;
      total++;
      if (req_ready !== 4'h0 || rsp_valid[2] !== 1'b1 || rsp_data[104:70] !== 35'h080800000) begin
        bad++; $display("FAIL bp_hold[%0d] ready=%b valid=%b data=%h exp ready=0000 valid=1 data=080800000",
                        k, req_ready, rsp_valid[2], rsp_data[104:70]);
      end
    end
    rsp_ready = 4'hF;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL bp_pop_cycle_ready got=%b exp=0000", req_ready); end
    tick;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_regrant got=%b exp=0100", req_ready); end
    total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL bp_popped got=%b exp=0000", rsp_valid); end
    req_valid = 4'h0;
    req_b[95:64] = 32'h40000000;
    tick;
  endtask

  task automatic test_flags;
    req_a[127:96] = 32'h7F800000;
    req_b[127:96] = 32'h00000000;
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL flags_grant got=%b exp=1000", req_ready); end
    tick;
    req_valid = 4'h0;
    tick;
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL flags_err_count got=%0d exp=1", err_count); end
    total++; if (ovf_count !== 16'd0) begin bad++; $display("FAIL flags_ovf_count got=%0d exp=0", ovf_count); end
    total++; if (rsp_data[139:105] !== 35'h480800000) begin bad++; $display("FAIL flags_data got=%h exp=480800000", rsp_data[139:105]); end
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL flags_full_ready got=%b exp=0000", req_ready); end
    tick;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL flags_regrant got=%b exp=1000", req_ready); end
    tick;
    req_valid = 4'h0;
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL flags_clr_priority got=%0d exp=0", err_count); end
    total++; if (err_count2 !== 2'd0) begin bad++; $display("FAIL flags_clr_priority2 got=%0d exp=0", err_count2); end
    tick;
  endtask

  task automatic test_saturation;
    set_all_ops(32'h7F000000, 32'h7F000000);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if ($countones(req_ready) != 1) begin
        bad++; $display("FAIL sat_one_per_cycle[%0d] got=%b exp=onehot", k, req_ready);
      end
      tick;
    end
    req_valid = 4'h0;
    tick;
    total++; if (ovf_count !== 16'd5) begin bad++; $display("FAIL sat_ovf_count got=%0d exp=5", ovf_count); end
    total++; if (ovf_count2 !== 2'd3) begin bad++; $display("FAIL sat_ovf_count2 got=%0d exp=3", ovf_count2); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL sat_err_count got=%0d exp=0", err_count); end
    set_all_ops(32'h3F800000, 32'h3F800000);
    tick; tick;
  endtask

  task automatic test_reset_midflight;
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_grant got=%b exp=0100", req_ready); end
    tick;
    req_valid = 4'b1010;
    rst_n = 1'b0;
    #1;
    total++; if (mul_active !== 1'b0) begin bad++; $display("FAIL mid_async_clear got=%b exp=0", mul_active); end
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    tick;
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready); end
    total++; if (ovf_count !== 16'd0) begin bad++; $display("FAIL mid_ovf_cleared got=%0d exp=0", ovf_count); end
    tick;
    req_valid = 4'h0;
    tick;
    total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL mid_no_stale_rsp got=%b exp=0010", rsp_valid); end
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_flags;
    test_saturation;
    test_reset_midflight;
    total++; if (inv_bad !== 0) begin bad++; $display("FAIL write_pop_invariant got=%0d exp=0", inv_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
